// File: rtl/herring_bus_timer.sv
// herring_bus_timer: 6502-bus peripheral with a prescaled 16-bit down-counting interval timer and IRQ
// Ports:
//   i_clk_src  50 MHz source clock, all logic on its rising edge
//   i_rst_n    asynchronous active-low reset
//   i_phi2     CPU PHI2, asynchronous, synchronised internally
//   i_cs_n     chip select from the address decoder, active low
//   i_rw       6502 RWB (1 = read, 0 = write)
//   i_rs       register select (0 CTRL, 1 STAT, 2 LO, 3 HI)
//   i_d_in     CPU data bus input
//   o_d_out    read data, 0 when not driving
//   o_d_oe     drive enable for o_d_out
//   o_irq_n    registered level interrupt request, active low
module herring_bus_timer #(
    parameter int PRESCALE    = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk_src,
    input  logic       i_rst_n,
    input  logic       i_phi2,
    input  logic       i_cs_n,
    input  logic       i_rw,
    input  logic [1:0] i_rs,
    input  logic [7:0] i_d_in,
    output logic [7:0] o_d_out,
    output logic       o_d_oe,
    output logic       o_irq_n
);
    localparam int PW = $clog2(PRESCALE);

    typedef enum logic [1:0] {IDLE, SAMPLE, COMMIT} bus_state_t;

    bus_state_t             r_state;
    bus_state_t             w_state_nxt;
    logic [SYNC_STAGES-1:0] r_phi2_sync;
    logic                   w_phi2_s;
    logic                   w_commit;
    logic                   r_cap_cs_n;
    logic                   r_cap_rw;
    logic [1:0]             r_cap_rs;
    logic [7:0]             r_cap_d;
    logic                   r_en;
    logic                   r_irqen;
    logic                   r_cont;
    logic                   r_exp;
    logic                   r_irq_n;
    logic [15:0]            r_count;
    logic [15:0]            r_reload;
    logic [7:0]             r_reload_hold;
    logic [7:0]             r_hi_snap;
    logic [PW-1:0]          r_pcnt;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_ctrl_wr;
    logic                   w_stat_wr;
    logic                   w_lo_wr;
    logic                   w_hi_wr;
    logic                   w_lo_rd;
    logic                   w_start;
    logic                   w_tick;
    logic                   w_expire;
    logic [7:0]             w_rd_mux;

    assign w_phi2_s = r_phi2_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk_src or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phi2_sync <= '0;
            r_state     <= IDLE;
        end else begin
            r_phi2_sync <= {r_phi2_sync[SYNC_STAGES-2:0], i_phi2};
            r_state     <= w_state_nxt;
        end
    end

    // COMMIT lasts exactly one clk after the synchronised falling edge of PHI2.
    always_comb begin
        w_commit    = (r_state == COMMIT);
        w_state_nxt = w_phi2_s ? SAMPLE : ((r_state == SAMPLE) ? COMMIT : IDLE);
    end

    // Bus pins are re-captured every clk PHI2 is high; the last capture is what commits.
    always_ff @(posedge i_clk_src or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_cs_n <= 1'b1;
            r_cap_rw   <= 1'b1;
            r_cap_rs   <= '0;
            r_cap_d    <= '0;
        end else if (w_phi2_s) begin
            r_cap_cs_n <= i_cs_n;
            r_cap_rw   <= i_rw;
            r_cap_rs   <= i_rs;
            r_cap_d    <= i_d_in;
        end
    end

    assign w_wr      = w_commit & ~r_cap_cs_n & ~r_cap_rw;
    assign w_rd      = w_commit & ~r_cap_cs_n & r_cap_rw;
    assign w_ctrl_wr = w_wr & (r_cap_rs == 2'd0);
    assign w_stat_wr = w_wr & (r_cap_rs == 2'd1);
    assign w_lo_wr   = w_wr & (r_cap_rs == 2'd2);
    assign w_hi_wr   = w_wr & (r_cap_rs == 2'd3);
    assign w_lo_rd   = w_rd & (r_cap_rs == 2'd2);
    assign w_start   = w_ctrl_wr & r_cap_d[0] & ~r_en;
    assign w_tick    = r_en & (r_pcnt == PW'(PRESCALE - 1));
    // A tick implies EN was already 1, so a start and an expiry never coincide.
    assign w_expire  = w_tick & (r_count == 16'd0);

    always_ff @(posedge i_clk_src or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en          <= 1'b0;
            r_irqen       <= 1'b0;
            r_cont        <= 1'b0;
            r_exp         <= 1'b0;
            r_irq_n       <= 1'b1;
            r_count       <= '0;
            r_reload      <= 16'hFFFF;
            r_reload_hold <= '0;
            r_hi_snap     <= '0;
            r_pcnt        <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_irqen <= r_cap_d[1];
                r_cont  <= r_cap_d[2];
            end
            // One-shot expiry forces EN low even against a simultaneous CTRL write.
            r_en    <= (w_expire & ~r_cont) ? 1'b0 : (w_ctrl_wr ? r_cap_d[0] : r_en);
            // Expiry set wins over a W1C landing in the same clk.
            r_exp   <= w_expire | (r_exp & ~(w_stat_wr & r_cap_d[0]));
            r_irq_n <= ~(r_exp & r_irqen);
            r_count <= (w_start | (w_expire & r_cont)) ? r_reload :
                       (w_tick & ~w_expire) ? r_count - 16'd1 : r_count;
            r_pcnt  <= (~r_en | w_tick) ? '0 : r_pcnt + 1'b1;
            if (w_lo_wr) r_reload_hold <= r_cap_d;
            if (w_hi_wr) r_reload <= {r_cap_d, r_reload_hold};
            if (w_lo_rd) r_hi_snap <= r_count[15:8];
        end
    end

    always_comb begin
        w_rd_mux = (i_rs == 2'd0) ? {5'b0, r_cont, r_irqen, r_en} :
                   (i_rs == 2'd1) ? {7'b0, r_exp} :
                   (i_rs == 2'd2) ? r_count[7:0] : r_hi_snap;
        o_d_oe   = ~i_cs_n & i_rw & i_phi2;
        o_d_out  = o_d_oe ? w_rd_mux : 8'h00;
    end

    assign o_irq_n = r_irq_n;
endmodule
